// File: rtl/rule30_stream_decrypt.sv
// Rule 30 keystream XOR decryptor for a framed valid/ready byte stream, one cycle latency.
// Optional feature macro RX_SYNC_ERR_EN adds a sticky sync_err output for framing violations.
module rule30_stream_decrypt #(
    parameter logic [7:0] SEED = 8'b00011000,
    parameter logic [7:0] RULE = 8'b00011110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] enc_in,
    input  logic       enc_valid,
    input  logic       enc_sof,
    input  logic       enc_last,
    output logic       enc_ready,
    output logic [7:0] dec_out,
    output logic       dec_valid,
    output logic       dec_last,
    input  logic       dec_ready,
    output logic [7:0] key_out,
    output logic [7:0] byte_cnt
`ifdef RX_SYNC_ERR_EN
    ,
    output logic       sync_err
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // One cellular-automaton generation with wrap-around neighbours; left neighbour is the select MSB.
    function automatic logic [7:0] rule_step(input logic [7:0] k);
        logic [7:0] n;
        logic [2:0] sel;
        n = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sel  = {k[3'(i + 7)], k[3'(i)], k[3'(i + 1)]};
            n[i] = RULE[sel];
        end
        return n;
    endfunction

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_key;
    logic [7:0] r_cnt;
    logic [7:0] r_dec_out;
    logic       r_dec_valid;
    logic       r_dec_last;
    logic       w_accept;
    logic       w_restart;
    logic       w_cont;
    logic       w_load;
    logic [7:0] w_key_next;

    assign enc_ready  = !r_dec_valid | dec_ready;
    assign w_accept   = enc_valid & enc_ready;
    assign w_restart  = w_accept & enc_sof;
    assign w_cont     = w_accept & !enc_sof & (r_state == ST_ACTIVE);
    assign w_load     = w_restart | w_cont;
    // A start of frame always rewinds the keystream to the shared seed.
    assign w_key_next = rule_step(w_restart ? SEED : r_key);

    assign dec_out   = r_dec_out;
    assign dec_valid = r_dec_valid;
    assign dec_last  = r_dec_last;
    assign key_out   = r_key;
    assign byte_cnt  = r_cnt;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: every decrypted byte either opens/continues a frame or closes it.
    always_comb begin
        w_state_next = r_state;
        if (w_load) begin
            if (enc_last) begin
                w_state_next = ST_IDLE;
            end else begin
                w_state_next = ST_ACTIVE;
            end
        end else begin
            w_state_next = r_state;
        end
    end

    // Output, key and byte-count registers; a stalled output holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key       <= SEED;
            r_cnt       <= 8'h00;
            r_dec_out   <= 8'h00;
            r_dec_valid <= 1'b0;
            r_dec_last  <= 1'b0;
        end else if (w_load) begin
            r_key       <= w_key_next;
            r_dec_out   <= enc_in ^ w_key_next;
            r_dec_valid <= 1'b1;
            r_dec_last  <= enc_last;
            if (w_restart) begin
                r_cnt <= 8'h01;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'h01;
            end else begin
                r_cnt <= r_cnt;
            end
        end else if (dec_ready) begin
            r_dec_valid <= 1'b0;
        end else begin
            r_dec_valid <= r_dec_valid;
        end
    end

`ifdef RX_SYNC_ERR_EN
    logic r_sync_err;
    assign sync_err = r_sync_err;

    // Sticky flag: orphan byte in IDLE or a restart in the middle of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_err <= 1'b0;
        end else if ((w_accept & !enc_sof & (r_state == ST_IDLE)) |
                     (w_restart & (r_state == ST_ACTIVE))) begin
            r_sync_err <= 1'b1;
        end else begin
            r_sync_err <= r_sync_err;
        end
    end
`endif

endmodule

// File: tb/tb_rule30_stream_decrypt.sv
// Self-checking bench for rule30_stream_decrypt: directed test-plan scenarios plus
// randomized traffic against a frame-level keystream reference model.
module tb_rule30_stream_decrypt;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] enc_in;
    logic       enc_valid;
    logic       enc_sof;
    logic       enc_last;
    logic       enc_ready;
    logic [7:0] dec_out;
    logic       dec_valid;
    logic       dec_last;
    logic       dec_ready;
    logic [7:0] key_out;
    logic [7:0] byte_cnt;
`ifdef RX_SYNC_ERR_EN
    logic       sync_err;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state (frame level)
    bit         m_valid;
    bit [7:0]   m_out;
    bit         m_last;
    bit         m_active;
    bit         m_err;
    int         m_n;
    int         m_cnt;

    rule30_stream_decrypt dut (
        .clk       (clk),
        .rst       (rst),
        .enc_in    (enc_in),
        .enc_valid (enc_valid),
        .enc_sof   (enc_sof),
        .enc_last  (enc_last),
        .enc_ready (enc_ready),
        .dec_out   (dec_out),
        .dec_valid (dec_valid),
        .dec_last  (dec_last),
        .dec_ready (dec_ready),
        .key_out   (key_out),
        .byte_cnt  (byte_cnt)
`ifdef RX_SYNC_ERR_EN
        ,
        .sync_err  (sync_err)
`endif
    );

    always #5 clk = ~clk;

    // Rule 30 generation written arithmetically: bit i = (30 >> (4*left + 2*centre + right)) & 1
    function automatic bit [7:0] ref_step(input bit [7:0] k);
        bit [7:0] r;
        int idx;
        for (int i = 0; i < 8; i++) begin
            idx  = 4 * k[(i + 7) % 8] + 2 * k[i] + k[(i + 1) % 8];
            r[i] = bit'((30 >> idx) & 1);
        end
        return r;
    endfunction

    // n-th keystream byte of a frame: K0 = 0x18, Kn = step applied n times
    function automatic bit [7:0] ks(input int n);
        bit [7:0] k;
        k = 8'h18;
        for (int i = 0; i < n; i++) k = ref_step(k);
        return k;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_out = 0; m_last = 0; m_active = 0; m_err = 0; m_n = 0; m_cnt = 0;
    endtask

    task automatic model_update(input bit v, input bit sof, input bit last, input bit [7:0] d, input bit rdy);
        bit acc;
        acc = v && (!m_valid || rdy);
        if (acc && ((!sof && !m_active) || (sof && m_active))) m_err = 1;
        if (acc && (sof || m_active)) begin
            if (sof) begin
                m_n = 1; m_cnt = 1;
            end else begin
                m_n++;
                if (m_cnt < 255) m_cnt++;
            end
            m_out = d ^ ks(m_n); m_last = last; m_valid = 1; m_active = !last;
        end else if (rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic set_in(input bit v, input bit sof, input bit last, input bit [7:0] d, input bit rdy);
        enc_valid = v; enc_sof = sof; enc_last = last; enc_in = d; dec_ready = rdy;
    endtask

    task automatic cyc(input bit v, input bit sof, input bit last, input bit [7:0] d, input bit rdy);
        set_in(v, sof, last, d, rdy);
        model_update(v, sof, last, d, rdy);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        set_in(0, 0, 0, 8'h00, 1);
        rst = 1'b1; #2; rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 8'h00, 0);
        rst = 1'b1;
        model_reset();
        #12;
        checks++; if (dec_out !== 8'h00) begin errors++; $display("FAIL reset_dec_out: got %h want 00", dec_out); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid); end
        checks++; if (dec_last !== 1'b0) begin errors++; $display("FAIL reset_dec_last: got %b want 0", dec_last); end
        checks++; if (key_out !== 8'h18) begin errors++; $display("FAIL reset_key: got %h want 18", key_out); end
        checks++; if (byte_cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h want 00", byte_cnt); end
        checks++; if (enc_ready !== 1'b1) begin errors++; $display("FAIL reset_enc_ready: got %b want 1", enc_ready); end
`ifdef RX_SYNC_ERR_EN
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b want 0", sync_err); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_frame();
        bit [7:0] bytes [3];
        bit [7:0] keys [3];
        bytes[0] = 8'h2C; bytes[1] = 8'h66; bytes[2] = 8'hBB;
        keys[0] = 8'h2C; keys[1] = 8'h66; keys[2] = 8'hBB;
        for (int i = 0; i < 3; i++) begin
            cyc(1, i == 0, i == 2, bytes[i], 1);
            checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL frame_valid%0d: got %b want 1", i, dec_valid); end
            checks++; if (dec_out !== 8'h00) begin errors++; $display("FAIL frame_out%0d: got %h want 00", i, dec_out); end
            checks++; if (dec_last !== (i == 2)) begin errors++; $display("FAIL frame_last%0d: got %b want %b", i, dec_last, i == 2); end
            checks++; if (key_out !== keys[i]) begin errors++; $display("FAIL frame_key%0d: got %h want %h", i, key_out, keys[i]); end
            checks++; if (byte_cnt !== 8'(i + 1)) begin errors++; $display("FAIL frame_cnt%0d: got %0d want %0d", i, byte_cnt, i + 1); end
        end
        cyc(0, 0, 0, 8'h00, 1);
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL frame_drain: got %b want 0", dec_valid); end
        checks++; if (byte_cnt !== 8'h03) begin errors++; $display("FAIL frame_cnt_hold: got %0d want 3", byte_cnt); end
    endtask

    task automatic test_single();
        cyc(1, 1, 1, 8'h6D, 1);
        checks++; if (dec_out !== 8'h41 || dec_last !== 1'b1 || dec_valid !== 1'b1) begin
            errors++; $display("FAIL single_out: got %h/%b/%b want 41/1/1", dec_out, dec_last, dec_valid); end
        cyc(1, 0, 0, 8'h77, 1);
        checks++; if (dec_valid !== 1'b0 || key_out !== 8'h2C) begin
            errors++; $display("FAIL single_idle_drop: got valid %b key %h want 0/2c", dec_valid, key_out); end
        cyc(1, 1, 1, 8'h2C, 1);
        checks++; if (dec_out !== 8'h00 || dec_valid !== 1'b1) begin
            errors++; $display("FAIL single_next_sof: got %h/%b want 00/1", dec_out, dec_valid); end
        cyc(0, 0, 0, 8'h00, 1);
    endtask

    task automatic test_drop();
        apply_reset();
        cyc(1, 0, 0, 8'h55, 1);
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL drop_valid: got %b want 0", dec_valid); end
        checks++; if (key_out !== 8'h18 || byte_cnt !== 8'h00) begin
            errors++; $display("FAIL drop_key_cnt: got %h/%0d want 18/0", key_out, byte_cnt); end
`ifdef RX_SYNC_ERR_EN
        checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL drop_sync_err: got %b want 1", sync_err); end
`endif
    endtask

    task automatic test_backpressure();
        apply_reset();
        cyc(1, 1, 0, 8'h10, 1);
        cyc(1, 0, 0, 8'h20, 1);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 8'h30, 0);
            #1;
            checks++; if (enc_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b want 0", i, enc_ready); end
            model_update(1, 0, 0, 8'h30, 0);
            @(posedge clk); #1;
            checks++; if (dec_out !== 8'h46 || dec_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold_out%0d: got %h/%b want 46/1", i, dec_out, dec_valid); end
            checks++; if (key_out !== 8'h66 || byte_cnt !== 8'h02) begin
                errors++; $display("FAIL bp_hold_key%0d: got %h/%0d want 66/2", i, key_out, byte_cnt); end
        end
        cyc(1, 0, 0, 8'h30, 1);
        checks++; if (dec_out !== 8'h8B || byte_cnt !== 8'h03 || key_out !== 8'hBB) begin
            errors++; $display("FAIL bp_resume: got %h/%0d/%h want 8b/3/bb", dec_out, byte_cnt, key_out); end
        cyc(1, 0, 1, 8'h40, 1);
        checks++; if (dec_out !== (8'h40 ^ ks(4)) || dec_last !== 1'b1) begin
            errors++; $display("FAIL bp_last: got %h/%b want %h/1", dec_out, dec_last, 8'h40 ^ ks(4)); end
        cyc(0, 0, 0, 8'h00, 1);
    endtask

    task automatic test_restart();
        apply_reset();
        cyc(1, 1, 0, 8'h11, 1);
        cyc(1, 1, 0, 8'h2C, 1);
        checks++; if (dec_out !== 8'h00 || byte_cnt !== 8'h01 || key_out !== 8'h2C || dec_last !== 1'b0) begin
            errors++; $display("FAIL restart_byte: got %h/%0d/%h/%b want 00/1/2c/0", dec_out, byte_cnt, key_out, dec_last); end
`ifdef RX_SYNC_ERR_EN
        checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL restart_sync_err: got %b want 1", sync_err); end
`endif
        cyc(1, 0, 1, 8'h66, 1);
        checks++; if (dec_out !== 8'h00 || dec_last !== 1'b1 || byte_cnt !== 8'h02) begin
            errors++; $display("FAIL restart_tail: got %h/%b/%0d want 00/1/2", dec_out, dec_last, byte_cnt); end
        cyc(0, 0, 0, 8'h00, 1);
    endtask

    task automatic test_async_reset();
        apply_reset();
        cyc(1, 1, 0, 8'h12, 0);
        cyc(1, 0, 0, 8'h34, 1);
        set_in(0, 0, 0, 8'h00, 0);
        #2; rst = 1'b1; #1;
        checks++; if (dec_valid !== 1'b0 || key_out !== 8'h18) begin
            errors++; $display("FAIL async_rst_immediate: got %b/%h want 0/18", dec_valid, key_out); end
        #1; rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        cyc(1, 0, 0, 8'h56, 1);
        checks++; if (dec_valid !== 1'b0 || key_out !== 8'h18 || byte_cnt !== 8'h00) begin
            errors++; $display("FAIL async_rst_drop: got %b/%h/%0d want 0/18/0", dec_valid, key_out, byte_cnt); end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            cyc(1, i == 0, i == 299, 8'($urandom), 1);
            checks++; if (dec_out !== m_out || byte_cnt !== 8'(m_cnt)) begin
                errors++; $display("FAIL sat_byte%0d: got %h/%0d want %h/%0d", i, dec_out, byte_cnt, m_out, m_cnt); end
        end
        checks++; if (byte_cnt !== 8'hFF || key_out !== ks(300)) begin
            errors++; $display("FAIL sat_end: got %0d/%h want 255/%h", byte_cnt, key_out, ks(300)); end
        cyc(0, 0, 0, 8'h00, 1);
    endtask

    task automatic test_random();
        bit v, sof, last, rdy;
        bit [7:0] d;
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            v = ($urandom_range(0, 3) != 0);
            sof = ($urandom_range(0, 9) == 0);
            last = ($urandom_range(0, 6) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            d = 8'($urandom);
            set_in(v, sof, last, d, rdy);
            #1;
            checks++; if (enc_ready !== (!m_valid || rdy)) begin
                errors++; $display("FAIL rnd_ready%0d: got %b want %b", i, enc_ready, !m_valid || rdy); end
            model_update(v, sof, last, d, rdy);
            @(posedge clk); #1;
            checks++; if (dec_valid !== m_valid) begin
                errors++; $display("FAIL rnd_valid%0d: got %b want %b", i, dec_valid, m_valid); end
            if (m_valid) begin
                checks++; if (dec_out !== m_out || dec_last !== m_last) begin
                    errors++; $display("FAIL rnd_data%0d: got %h/%b want %h/%b", i, dec_out, dec_last, m_out, m_last); end
            end
            checks++; if (key_out !== ks(m_n) || byte_cnt !== 8'(m_cnt)) begin
                errors++; $display("FAIL rnd_key%0d: got %h/%0d want %h/%0d", i, key_out, byte_cnt, ks(m_n), m_cnt); end
`ifdef RX_SYNC_ERR_EN
            checks++; if (sync_err !== m_err) begin
                errors++; $display("FAIL rnd_sync_err%0d: got %b want %b", i, sync_err, m_err); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_single();
        test_drop();
        test_backpressure();
        test_restart();
        test_async_reset();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
